// File: rtl/inst_decode_buffer.sv
// Decoded-instruction buffer: decodes RV32 base words at push, queues DEPTH entries.
// Build option: INST_DECODE_CUSTOM0_EN adds the custom-0 (0001011) I-form opcode.
module inst_decode_buffer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2:0]                 out_type,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [2:0]                 out_funct3,
  output logic [6:0]                 out_funct7,
  output logic [XLEN-1:0]            out_imm,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                illegal_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [2:0] T_R   = 3'd0;
  localparam logic [2:0] T_I   = 3'd1;
  localparam logic [2:0] T_S   = 3'd2;
  localparam logic [2:0] T_B   = 3'd3;
  localparam logic [2:0] T_U   = 3'd4;
  localparam logic [2:0] T_J   = 3'd5;
  localparam logic [2:0] T_ILL = 3'd7;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [6:0] OP_U = 7'b0010111;
  localparam logic [6:0] OP_J = 7'b1101111;
`ifdef INST_DECODE_CUSTOM0_EN
  localparam logic [2:0] T_C0  = 3'd6;
  localparam logic [6:0] OP_C0 = 7'b0001011;
`endif

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [2:0]      typ;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_valid;
  logic [15:0]     r_ill_cnt;

  entry_t          w_dec;
  entry_t          w_head;
  logic            w_bad;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_count_nxt;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;

  assign w_f3 = in_inst[14:12];
  assign w_f7 = in_inst[31:25];

  // Sign-extended immediates for every format
  assign w_imm_i = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
  assign w_imm_s = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign w_imm_b = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7],
                    in_inst[30:25], in_inst[11:8], 1'b0};
  assign w_imm_u = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
  assign w_imm_j = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12],
                    in_inst[20], in_inst[30:21], 1'b0};

  // Decode of the incoming word; any failed field check collapses to ILLEGAL
  always_comb begin
    w_dec     = '0;
    w_bad     = 1'b0;
    w_dec.rd  = in_inst[11:7];
    w_dec.rs1 = in_inst[19:15];
    w_dec.rs2 = in_inst[24:20];
    w_dec.f3  = w_f3;
    w_dec.f7  = w_f7;
    case (in_inst[6:0])
      OP_R: begin
        w_dec.typ = T_R;
        if ((w_f7 != F7_ZERO) && (w_f7 != F7_ALT)) begin
          w_bad = 1'b1;
        end else if ((w_f7 == F7_ALT) && (w_f3 != 3'b000) && (w_f3 != 3'b101)) begin
          w_bad = 1'b1;
        end
      end
      OP_I: begin
        w_dec.typ = T_I;
        w_dec.imm = w_imm_i;
        if ((w_f3 == 3'b001) && (w_f7 != F7_ZERO)) begin
          w_bad = 1'b1;
        end
        if ((w_f3 == 3'b101) && (w_f7 != F7_ZERO) && (w_f7 != F7_ALT)) begin
          w_bad = 1'b1;
        end
      end
      OP_S: begin
        w_dec.typ = T_S;
        w_dec.imm = w_imm_s;
        w_bad     = (w_f3 > 3'b010);
      end
      OP_B: begin
        w_dec.typ = T_B;
        w_dec.imm = w_imm_b;
        w_bad     = (w_f3 == 3'b010) || (w_f3 == 3'b011);
      end
      OP_U: begin
        w_dec.typ = T_U;
        w_dec.imm = w_imm_u;
      end
      OP_J: begin
        w_dec.typ = T_J;
        w_dec.imm = w_imm_j;
      end
`ifdef INST_DECODE_CUSTOM0_EN
      OP_C0: begin
        w_dec.typ = T_C0;
        w_dec.imm = w_imm_i;
        w_bad     = (w_f3 != 3'b000);
      end
`endif
      default: w_bad = 1'b1;
    endcase
    if (w_bad) begin
      w_dec.typ = T_ILL;
      w_dec.imm = '0;
    end
  end

  // Handshakes; flush overrides both sides
  assign in_ready = (r_count < CW'(DEPTH));
  assign w_push   = in_valid && in_ready && !flush;
  assign w_pop    = r_valid && out_ready && !flush;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
    end
  end

  // Entry storage needs no reset: reads are gated by r_valid
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ill_cnt <= '0;
    end else if (w_push && (w_dec.typ == T_ILL) && (r_ill_cnt != 16'hFFFF)) begin
      r_ill_cnt <= r_ill_cnt + 16'd1;
    end
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign out_valid   = r_valid;
  assign out_type    = r_valid ? w_head.typ : '0;
  assign out_rd      = r_valid ? w_head.rd  : '0;
  assign out_rs1     = r_valid ? w_head.rs1 : '0;
  assign out_rs2     = r_valid ? w_head.rs2 : '0;
  assign out_funct3  = r_valid ? w_head.f3  : '0;
  assign out_funct7  = r_valid ? w_head.f7  : '0;
  assign out_imm     = r_valid ? w_head.imm : '0;
  assign out_illegal = r_valid && (w_head.typ == T_ILL);
  assign count       = r_count;
  assign illegal_cnt = r_ill_cnt;

endmodule

// File: tb/tb_inst_decode_buffer.sv
// Bench for inst_decode_buffer: queue-based reference model plus directed literal checks.
module tb_inst_decode_buffer;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_inst = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [2:0]      out_type;
  logic [4:0]      out_rd, out_rs1, out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;
  logic [CW-1:0]   count;
  logic [15:0]     illegal_cnt;

  inst_decode_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_type(out_type), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
    .out_illegal(out_illegal), .count(count), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the ISA field rules
  function automatic void mdec(input bit [31:0] i, output int typ, output bit [63:0] imm);
    bit [6:0]            op;
    bit [2:0]            f3;
    bit [6:0]            f7;
    logic signed [11:0]  s12;
    logic signed [12:0]  s13;
    logic signed [20:0]  s21;
    logic signed [31:0]  s32;
    longint              v;
    op = i[6:0];
    f3 = i[14:12];
    f7 = i[31:25];
    v  = 0;
    typ = 7;
    case (op)
      7'b0110011: begin
        typ = ((f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) ? 0 : 7;
      end
      7'b0010011: begin
        typ = 1;
        if (f3 == 1 && f7 != 0) typ = 7;
        if (f3 == 5 && f7 != 0 && f7 != 7'h20) typ = 7;
        s12 = i[31:20]; v = s12;
      end
      7'b0100011: begin
        typ = (f3 <= 2) ? 2 : 7;
        s12 = {i[31:25], i[11:7]}; v = s12;
      end
      7'b1100011: begin
        typ = (f3 == 2 || f3 == 3) ? 7 : 3;
        s13 = {i[31], i[7], i[30:25], i[11:8], 1'b0}; v = s13;
      end
      7'b0010111: begin
        typ = 4;
        s32 = {i[31:12], 12'b0}; v = s32;
      end
      7'b1101111: begin
        typ = 5;
        s21 = {i[31], i[19:12], i[20], i[30:21], 1'b0}; v = s21;
      end
`ifdef INST_DECODE_CUSTOM0_EN
      7'b0001011: begin
        typ = (f3 == 0) ? 6 : 7;
        s12 = i[31:20]; v = s12;
      end
`endif
      default: typ = 7;
    endcase
    imm = 64'(v);
    if (XLEN == 32) imm[63:32] = '0;
    if (typ == 7) imm = '0;
  endfunction

  bit [31:0] mq[$];
  int        mill = 0;

  // Model state update: mirrors the handshake rules on the same edges
  always @(posedge clk or negedge rst_n) begin : model_upd
    int  t;
    bit  [63:0] im;
    bit  push, pop;
    if (!rst_n) begin
      mq.delete();
      mill = 0;
    end else begin
      push = in_valid && (mq.size() < DEPTH) && !flush;
      pop  = (mq.size() > 0) && out_ready && !flush;
      if (flush) begin
        mq.delete();
      end else begin
        if (pop) void'(mq.pop_front());
        if (push) begin
          mq.push_back(in_inst);
          mdec(in_inst, t, im);
          if (t == 7 && mill < 65535) mill++;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin : compare
    int  t;
    bit  [63:0] im;
    bit  [31:0] h;
    check("count", 64'(count), 64'(mq.size()));
    check("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
    check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    check("illegal_cnt", 64'(illegal_cnt), 64'(mill));
    if (mq.size() > 0) begin
      h = mq[0];
      mdec(h, t, im);
      check("out_type", 64'(out_type), 64'(t));
      check("out_rd", 64'(out_rd), 64'(h[11:7]));
      check("out_rs1", 64'(out_rs1), 64'(h[19:15]));
      check("out_rs2", 64'(out_rs2), 64'(h[24:20]));
      check("out_funct3", 64'(out_funct3), 64'(h[14:12]));
      check("out_funct7", 64'(out_funct7), 64'(h[31:25]));
      check("out_imm", 64'(out_imm), im);
      check("out_illegal", 64'(out_illegal), 64'(t == 7));
    end else begin
      check("idle_fields", {out_type, out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
                            out_illegal}, '0);
      check("idle_imm", 64'(out_imm), '0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic bit [31:0] addi_word(input int n);
    return {12'(n + 1), 5'd0, 3'b000, 5'(n + 1), 7'b0010011};
  endfunction

  bit [31:0] stream [14] = '{
    32'h00B50533, 32'h40B50533, 32'h02B50533, 32'h40B51533,
    32'h00351513, 32'h02051513, 32'h4015D593, 32'h00A12423,
    32'h00A13423, 32'hFE0A2EE3, 32'h12345097, 32'h123450B7,
    32'hFFDFF0EF, 32'h0000100B
  };

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 64'(count), 0);
    check("rst_in_ready", 64'(in_ready), 1);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_illegal_cnt", 64'(illegal_cnt), 0);
    rst_n = 1'b1;
    cyc();

    // addi x1,x0,-1
    in_valid = 1'b1; in_inst = 32'hFFF00093; cyc(); in_valid = 1'b0;
    check("addi_valid", 64'(out_valid), 1);
    check("addi_type", 64'(out_type), 1);
    check("addi_rd", 64'(out_rd), 1);
    check("addi_rs1", 64'(out_rs1), 0);
    check("addi_imm", 64'(out_imm), 64'hFFFF_FFFF);
    out_ready = 1'b1; cyc(); out_ready = 1'b0;
    check("addi_drained", 64'(count), 0);

    // beq x0,x0,-4
    in_valid = 1'b1; in_inst = 32'hFE000EE3; cyc(); in_valid = 1'b0;
    check("beq_type", 64'(out_type), 3);
    check("beq_imm", 64'(out_imm), 64'hFFFF_FFFC);
    check("beq_illegal", 64'(out_illegal), 0);
    out_ready = 1'b1; cyc(); out_ready = 1'b0;

    // Fill to DEPTH with a fifth word held back
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_inst = addi_word(i); cyc();
    end
    in_inst = addi_word(4); cyc();
    check("full_count", 64'(count), 4);
    check("full_in_ready", 64'(in_ready), 0);
    check("full_head_rd", 64'(out_rd), 1);
    out_ready = 1'b1; cyc();
    check("pop1_head_rd", 64'(out_rd), 2);
    check("pop1_count", 64'(count), 3);
    cyc();
    in_valid = 1'b0;
    repeat (3) cyc();
    check("full_drained", 64'(count), 0);
    out_ready = 1'b0;

    // Two illegal words
    in_valid = 1'b1; in_inst = 32'h00000000; cyc();
    in_inst = 32'h40001033; cyc(); in_valid = 1'b0;
    check("ill_count", 64'(count), 2);
    check("ill_type0", 64'(out_type), 7);
    check("ill_flag0", 64'(out_illegal), 1);
    check("ill_cnt", 64'(illegal_cnt), 2);
    out_ready = 1'b1; cyc();
    check("ill_type1", 64'(out_type), 7);
    check("ill_flag1", 64'(out_illegal), 1);
    cyc(); out_ready = 1'b0;

    // Flush beats concurrent push and pop
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_inst = addi_word(i + 8); cyc();
    end
    check("pre_flush_count", 64'(count), 3);
    flush = 1'b1; out_ready = 1'b1; in_inst = 32'h00000000; cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush_count", 64'(count), 0);
    check("flush_valid", 64'(out_valid), 0);
    check("flush_ill_cnt", 64'(illegal_cnt), 2);
    cyc();
    check("flush_dropped", 64'(count), 0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_inst = addi_word(i + 12); cyc();
    end
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("arst_count", 64'(count), 0);
    check("arst_valid", 64'(out_valid), 0);
    check("arst_ill_cnt", 64'(illegal_cnt), 0);
    check("arst_in_ready", 64'(in_ready), 1);
    @(posedge clk); #2 rst_n = 1'b1;
    in_valid = 1'b1; in_inst = 32'hFFF00093; cyc(); in_valid = 1'b0;
    check("post_rst_valid", 64'(out_valid), 1);
    check("post_rst_type", 64'(out_type), 1);
    out_ready = 1'b1; cyc(); out_ready = 1'b0;

    // custom-0 opcode
    in_valid = 1'b1; in_inst = 32'h0000000B; cyc(); in_valid = 1'b0;
`ifdef INST_DECODE_CUSTOM0_EN
    check("custom0_type", 64'(out_type), 6);
`else
    check("custom0_type", 64'(out_type), 7);
`endif
    out_ready = 1'b1; cyc();

    // Streaming with simultaneous push/pop through pointer wrap
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1; in_inst = stream[i]; cyc();
    end
    in_valid = 1'b0;
    repeat (3) cyc();
    check("stream_drained", 64'(count), 0);
    out_ready = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
